cp0_regfile_p: RTL and testbench

//  Parametrised CP0 register file: BadVAddr, Count, Compare, Status, Cause, EPC, PRId, Config.

---
 rtl/cp0_regfile_p_if.sv | 19 +
 rtl/cp0_regfile_p.sv | 187 ++++++++++++++++++
 tb/tb_cp0_regfile_p.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cp0_regfile_p_if.sv
// mtc0/mfc0 access bus for the CP0 register file.
// master = pipeline side, slave = cp0_regfile_p.
interface cp0_regfile_p_if;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] data_i;
  logic [4:0]  raddr_i;
  logic [31:0] data_o;

  modport master (
    output we_i, waddr_i, data_i, raddr_i,
    input  data_o
  );

  modport slave (
    input  we_i, waddr_i, data_i, raddr_i,
    output data_o
  );
endinterface

// File: rtl/cp0_regfile_p.sv
// CP0 register file: timer, interrupt sync, exception/ERET state.
// Count/Compare/TI exist only when CP0_TIMER_EN is defined.
module cp0_regfile_p #(
  parameter int          HW_INT_NUM   = 6,
  parameter int          COUNT_DIV    = 1,
  parameter logic [31:0] STATUS_WMASK = 32'h0000_FF03,
  parameter logic [31:0] STATUS_RST   = 32'h0040_0000,
  parameter logic [31:0] PRID_VALUE   = 32'h004C_0102,
  parameter logic [31:0] CONFIG_VALUE = 32'h0000_8000
) (
  input  logic                  clk,
  input  logic                  rst,
  cp0_regfile_p_if.slave        bus,
  input  logic [HW_INT_NUM-1:0] int_i,
  input  logic                  exc_valid_i,
  input  logic [4:0]            exc_code_i,
  input  logic [31:0]           epc_i,
  input  logic                  in_delayslot_i,
  input  logic                  badvaddr_we_i,
  input  logic [31:0]           badvaddr_i,
  input  logic                  eret_i,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic [31:0]           epc_o,
  output logic                  exl_o,
  output logic                  timer_int_o,
  output logic                  int_req_o
);
  localparam logic [4:0] A_BADV   = 5'd8;
  localparam logic [4:0] A_COUNT  = 5'd9;
  localparam logic [4:0] A_COMP   = 5'd11;
  localparam logic [4:0] A_STATUS = 5'd12;
  localparam logic [4:0] A_CAUSE  = 5'd13;
  localparam logic [4:0] A_EPC    = 5'd14;
  localparam logic [4:0] A_PRID   = 5'd15;
  localparam logic [4:0] A_CONFIG = 5'd16;

  if (HW_INT_NUM < 1 || HW_INT_NUM > 6 ||
      COUNT_DIV < 1 || COUNT_DIV > 2) begin : g_bad_param
    $error("cp0_regfile_p: bad parameter");
  end

  logic [HW_INT_NUM-1:0] r_sync1;
  logic [HW_INT_NUM-1:0] r_sync2;
  logic [31:0] r_badv;
  logic [31:0] r_status;
  logic [31:0] r_epc;
  logic        r_bd;
  logic [1:0]  r_ip_sw;
  logic [4:0]  r_exc;
  logic        r_int_req;

  logic        w_exl;
  logic        w_eret;
  logic        w_wr;
  logic        w_ti;
  logic [31:0] w_count;
  logic [31:0] w_compare;
  logic [5:0]  w_ip_hw;
  logic [7:0]  w_ip;
  logic [31:0] w_cause;

  // exception > eret > mtc0; losers are dropped
  assign w_exl  = r_status[1];
  assign w_eret = eret_i & ~exc_valid_i;
  assign w_wr   = bus.we_i & ~exc_valid_i & ~eret_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= int_i;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_ip_hw = '0;
    w_ip_hw[HW_INT_NUM-1:0] = r_sync2;
  end

  assign w_ip    = {w_ip_hw[5] | w_ti, w_ip_hw[4:0], r_ip_sw};
  assign w_cause = {r_bd, w_ti, 14'd0, w_ip,
                    1'b0, r_exc, 2'b00};

`ifdef CP0_TIMER_EN
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_ti;
  logic        r_pre;
  logic        w_tick;

  assign w_tick = (COUNT_DIV == 1) ? 1'b1 : r_pre;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count   <= '0;
      r_compare <= 32'hFFFF_FFFF;
      r_ti      <= 1'b0;
      r_pre     <= 1'b0;
    end else begin
      if (w_wr && bus.waddr_i == A_COUNT) begin
        r_count <= bus.data_i;
        r_pre   <= 1'b0;
      end else begin
        if (w_tick) r_count <= r_count + 32'd1;
        r_pre <= ~r_pre;
      end
      // a Compare write beats a same-cycle hit
      if (w_wr && bus.waddr_i == A_COMP) begin
        r_compare <= bus.data_i;
        r_ti      <= 1'b0;
      end else if (r_count == r_compare) begin
        r_ti <= 1'b1;
      end
    end
  end

  assign w_ti      = r_ti;
  assign w_count   = r_count;
  assign w_compare = r_compare;
`else
  assign w_ti      = 1'b0;
  assign w_count   = '0;
  assign w_compare = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_badv    <= '0;
      r_status  <= STATUS_RST;
      r_epc     <= '0;
      r_bd      <= 1'b0;
      r_ip_sw   <= '0;
      r_exc     <= '0;
      r_int_req <= 1'b0;
    end else begin
      r_int_req <= r_status[0] & ~w_exl &
                   (|(w_ip & r_status[15:8]));
      if (exc_valid_i) begin
        // nested exceptions keep the outer EPC/BD
        if (!w_exl) begin
          r_epc <= in_delayslot_i ? epc_i - 32'd4 : epc_i;
          r_bd  <= in_delayslot_i;
        end
        r_status[1] <= 1'b1;
        r_exc       <= exc_code_i;
        if (badvaddr_we_i &&
            (exc_code_i == 5'd4 || exc_code_i == 5'd5))
          r_badv <= badvaddr_i;
      end else if (w_eret) begin
        r_status[1] <= 1'b0;
      end else if (w_wr) begin
        case (bus.waddr_i)
          A_STATUS: r_status <= (r_status & ~STATUS_WMASK) |
                               (bus.data_i & STATUS_WMASK);
          A_CAUSE:  r_ip_sw  <= bus.data_i[9:8];
          A_EPC:    r_epc    <= bus.data_i;
          default:  ;
        endcase
      end
    end
  end

  always_comb begin
    bus.data_o = '0;
    case (bus.raddr_i)
      A_BADV:   bus.data_o = r_badv;
      A_COUNT:  bus.data_o = w_count;
      A_COMP:   bus.data_o = w_compare;
      A_STATUS: bus.data_o = r_status;
      A_CAUSE:  bus.data_o = w_cause;
      A_EPC:    bus.data_o = r_epc;
      A_PRID:   bus.data_o = PRID_VALUE;
      A_CONFIG: bus.data_o = CONFIG_VALUE;
      default:  bus.data_o = '0;
    endcase
  end

  assign status_o    = r_status;
  assign cause_o     = w_cause;
  assign epc_o       = r_epc;
  assign exl_o       = w_exl;
  assign timer_int_o = w_ti;
  assign int_req_o   = r_int_req;
endmodule

// File: tb/tb_cp0_regfile_p.sv
// Bench for cp0_regfile_p: directed steps, then random ops vs a model.
// Timer checks follow CP0_TIMER_EN like the design.
module tb_cp0_regfile_p;
  localparam int N = 6;
  localparam logic [31:0] SMASK = 32'h0000_FF03;
  localparam logic [31:0] SRST  = 32'h0040_0000;
  localparam logic [31:0] PRID  = 32'h004C_0102;
  localparam logic [31:0] CONF  = 32'h0000_8000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] int_i;
  logic exc_valid_i, in_delayslot_i, badvaddr_we_i, eret_i;
  logic [4:0] exc_code_i;
  logic [31:0] epc_i, badvaddr_i;
  logic [31:0] status_o, cause_o, epc_o;
  logic exl_o, timer_int_o, int_req_o;

  int checks = 0;
  int failures = 0;

  cp0_regfile_p_if bus();

  cp0_regfile_p dut (
    .clk(clk), .rst(rst), .bus(bus),
    .int_i(int_i),
    .exc_valid_i(exc_valid_i), .exc_code_i(exc_code_i),
    .epc_i(epc_i), .in_delayslot_i(in_delayslot_i),
    .badvaddr_we_i(badvaddr_we_i), .badvaddr_i(badvaddr_i),
    .eret_i(eret_i),
    .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o),
    .exl_o(exl_o), .timer_int_o(timer_int_o),
    .int_req_o(int_req_o)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    bus.we_i = 1'b0; bus.waddr_i = '0; bus.data_i = '0;
    exc_valid_i = 1'b0; exc_code_i = '0; epc_i = '0;
    in_delayslot_i = 1'b0; badvaddr_we_i = 1'b0;
    badvaddr_i = '0; eret_i = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    idle_in();
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.we_i = 1'b1; bus.waddr_i = a; bus.data_i = d;
    tick();
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] v);
    bus.raddr_i = a; #1;
    v = bus.data_o;
  endtask

  task automatic chkrd(input string tag, input logic [4:0] a,
                       input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    chk(tag, v, exp);
  endtask

  // reference state (fields, not registers)
  logic [31:0] m_status, m_epc, m_badv;
  logic        m_bd;
  logic [1:0]  m_ipsw;
  logic [4:0]  m_code;

  function automatic logic [31:0] m_cause();
    logic [31:0] c;
    c = 32'd0;
    c = c | (32'(m_bd) << 31);
    c = c | (32'(m_ipsw) << 8);
    c = c | (32'(m_code) << 2);
    return c;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_badv;
      5'd12:   return m_status;
      5'd13:   return m_cause();
      5'd14:   return m_epc;
      5'd15:   return PRID;
      5'd16:   return CONF;
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    logic [31:0] v, a0;
    logic found;
    logic exp_req;
    logic [4:0] wtab [8];
    logic [4:0] rtab [10];
    wtab = '{5'd8, 5'd12, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd3};
    rtab = '{5'd8, 5'd12, 5'd13, 5'd14, 5'd15,
             5'd16, 5'd0, 5'd10, 5'd17, 5'd31};
    idle_in();
    int_i = '0;
    bus.raddr_i = '0;
    #2 rst = 1'b0;

    // 1. reset state
    tick();
    chk("rst_status", status_o, SRST);
    chk("rst_cause", cause_o, 32'd0);
    chk("rst_epc", epc_o, 32'd0);
    chk("rst_intreq", 32'(int_req_o), 32'd0);
    chk("rst_timer", 32'(timer_int_o), 32'd0);
    tick();
    rst = 1'b1;
    chkrd("rd_status", 5'd12, SRST);
    chkrd("rd_prid", 5'd15, PRID);
    chkrd("rd_cause", 5'd13, 32'd0);
    tick();
    chkrd("rd_config", 5'd16, CONF);
    chkrd("rd_badv", 5'd8, 32'd0);
`ifdef CP0_TIMER_EN
    rd(5'd9, a0);
    tick();
    chkrd("count_inc", 5'd9, a0 + 32'd1);

    // 2. timer
    mtc0(5'd9, 32'd10);
    mtc0(5'd11, 32'd15);
    chk("ti_before", 32'(timer_int_o), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (timer_int_o) found = 1'b1;
    end
    chk("ti_fire", 32'(found), 32'd1);
    chkrd("ti_count", 5'd9, 32'd16);
    chk("ti_cause", 32'(cause_o[30]), 32'd1);
    mtc0(5'd11, 32'd100);
    chk("ti_clear", 32'(timer_int_o), 32'd0);
    mtc0(5'd9, 32'd50);
    mtc0(5'd11, 32'd52);
    tick();
    chkrd("hit_count", 5'd9, 32'd52);
    mtc0(5'd11, 32'hFFFF_0000);
    chk("hit_wr_wins", 32'(timer_int_o), 32'd0);
    tick();
    chk("hit_wr_wins2", 32'(timer_int_o), 32'd0);
`else
    mtc0(5'd9, 32'd10);
    chkrd("nt_count", 5'd9, 32'd0);
    mtc0(5'd11, 32'd12);
    chkrd("nt_compare", 5'd11, 32'd0);
    for (int i = 0; i < 12; i++) tick();
    chk("nt_timer", 32'(timer_int_o), 32'd0);
`endif

    // 3. hardware interrupt latency and masking
    mtc0(5'd12, 32'h0000_0401);
    int_i[0] = 1'b1;
    tick();
    chk("irq_c1", 32'(int_req_o), 32'd0);
    tick();
    chk("irq_ip2", 32'(cause_o[10]), 32'd1);
    chk("irq_c2", 32'(int_req_o), 32'd0);
    tick();
    chk("irq_c3", 32'(int_req_o), 32'd1);
    mtc0(5'd12, 32'h0000_0001);
    tick();
    chk("irq_im0", 32'(int_req_o), 32'd0);
    mtc0(5'd12, 32'h0000_0403);
    tick();
    chk("irq_exl", 32'(int_req_o), 32'd0);
    int_i = '0;
    mtc0(5'd12, 32'd0);
    tick(); tick(); tick();
    chk("irq_off_ip", 32'(cause_o[15:8]), 32'd0);

    // 4. exceptions
    exc_valid_i = 1'b1; exc_code_i = 5'h04;
    epc_i = 32'h100; in_delayslot_i = 1'b1;
    badvaddr_we_i = 1'b1; badvaddr_i = 32'hDEAD_BEE1;
    tick();
    chk("exc_epc", epc_o, 32'hFC);
    chk("exc_cause", cause_o, 32'h8000_0010);
    chk("exc_exl", 32'(exl_o), 32'd1);
    chkrd("exc_badv", 5'd8, 32'hDEAD_BEE1);
    exc_valid_i = 1'b1; exc_code_i = 5'h08;
    epc_i = 32'h200; badvaddr_we_i = 1'b1;
    badvaddr_i = 32'h1234_5678;
    tick();
    chk("nest_epc", epc_o, 32'hFC);
    chk("nest_cause", cause_o, 32'h8000_0020);
    chkrd("nest_badv", 5'd8, 32'hDEAD_BEE1);

    // 5. eret and same-cycle priority
    eret_i = 1'b1;
    tick();
    chk("eret_exl", 32'(exl_o), 32'd0);
    chk("eret_epc", epc_o, 32'hFC);
    exc_valid_i = 1'b1; exc_code_i = 5'h00; epc_i = 32'h300;
    eret_i = 1'b1;
    bus.we_i = 1'b1; bus.waddr_i = 5'd14; bus.data_i = 32'h55;
    tick();
    chk("prio_exl", 32'(exl_o), 32'd1);
    chk("prio_epc", epc_o, 32'h300);
    chk("prio_cause", cause_o, 32'd0);
    eret_i = 1'b1;
    tick();
    chk("prio_eret", 32'(exl_o), 32'd0);

    // 6. asynchronous reset mid-operation
    mtc0(5'd12, 32'h0000_FF01);
    mtc0(5'd14, 32'hABCD_0000);
`ifdef CP0_TIMER_EN
    mtc0(5'd9, 32'd5);
    mtc0(5'd11, 32'd6);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (timer_int_o) found = 1'b1;
    end
    chk("ar_ti_set", 32'(found), 32'd1);
`endif
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("ar_timer", 32'(timer_int_o), 32'd0);
    chk("ar_status", status_o, SRST);
    chk("ar_cause", cause_o, 32'd0);
    chk("ar_epc", epc_o, 32'd0);
    chk("ar_intreq", 32'(int_req_o), 32'd0);
    chkrd("ar_count", 5'd9, 32'd0);
`ifdef CP0_TIMER_EN
    chkrd("ar_compare", 5'd11, 32'hFFFF_FFFF);
`else
    chkrd("ar_compare", 5'd11, 32'd0);
`endif
    tick(); tick();
    rst = 1'b1;

    // 7. random ops against the model
    m_status = SRST; m_epc = '0; m_badv = '0;
    m_bd = 1'b0; m_ipsw = '0; m_code = '0;
    for (int i = 0; i < 300; i++) begin
      exc_valid_i = ($urandom_range(0, 4) == 0);
      eret_i = ($urandom_range(0, 3) == 0);
      bus.we_i = ($urandom_range(0, 1) == 1);
      bus.waddr_i = wtab[$urandom_range(0, 7)];
      bus.data_i = $urandom;
      exc_code_i = 5'($urandom_range(0, 7));
      epc_i = $urandom;
      in_delayslot_i = ($urandom_range(0, 1) == 1);
      badvaddr_we_i = ($urandom_range(0, 1) == 1);
      badvaddr_i = $urandom;
      exp_req = m_status[0] && !m_status[1] &&
                ((m_ipsw & m_status[9:8]) != 2'b00);
      if (exc_valid_i) begin
        if (!m_status[1]) begin
          m_epc = in_delayslot_i ? epc_i - 32'd4 : epc_i;
          m_bd = in_delayslot_i;
        end
        m_status[1] = 1'b1;
        m_code = exc_code_i;
        if (badvaddr_we_i && (exc_code_i == 5'd4 ||
                              exc_code_i == 5'd5))
          m_badv = badvaddr_i;
      end else if (eret_i) begin
        m_status[1] = 1'b0;
      end else if (bus.we_i) begin
        if (bus.waddr_i == 5'd12)
          m_status = (m_status & ~SMASK) | (bus.data_i & SMASK);
        else if (bus.waddr_i == 5'd13)
          m_ipsw = bus.data_i[9:8];
        else if (bus.waddr_i == 5'd14)
          m_epc = bus.data_i;
      end
      tick();
      chk("rnd_status", status_o, m_status);
      chk("rnd_cause", cause_o, m_cause());
      chk("rnd_epc", epc_o, m_epc);
      chk("rnd_exl", 32'(exl_o), 32'(m_status[1]));
      chk("rnd_intreq", 32'(int_req_o), 32'(exp_req));
      a0 = 32'(rtab[$urandom_range(0, 9)]);
      chkrd("rnd_read", a0[4:0], m_read(a0[4:0]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
